// File: rtl/clint_multi_hart.sv
// Core-local interruptor: prescaled 64-bit mtime, per-hart mtimecmp/msip, and
// single-outstanding AXI read/write slave channels driving registered mtip/msip_o.
module clint_multi_hart #(
  parameter int unsigned NHART    = 1,
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned IDW      = 4
) (
  input  logic             clock,
  input  logic             reset,
  // read: AR/R channels
  input  logic [15:0]      i_araddr,
  input  logic [IDW-1:0]   i_arid,
  input  logic             i_arvalid,
  output logic             o_arready,
  output logic [31:0]      o_rdata,
  output logic [1:0]       o_rresp,
  output logic             o_rlast,
  output logic [IDW-1:0]   o_rid,
  output logic             o_rvalid,
  input  logic             i_rready,
  // write: AW/W/B channels
  input  logic [15:0]      i_awaddr,
  input  logic [IDW-1:0]   i_awid,
  input  logic             i_awvalid,
  output logic             o_awready,
  input  logic [31:0]      i_wdata,
  input  logic [3:0]       i_wstrb,
  input  logic             i_wvalid,
  output logic             o_wready,
  output logic [1:0]       o_bresp,
  output logic [IDW-1:0]   o_bid,
  output logic             o_bvalid,
  input  logic             i_bready,
  output logic [NHART-1:0] mtip,
  output logic [NHART-1:0] msip_o
);

  localparam int unsigned PW          = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {T_NONE, T_MSIP, T_CMP, T_MTIME} tgt_e;
  typedef struct packed {
    tgt_e       tgt;
    logic [2:0] hart;
    logic       hi;
  } dec_t;

  typedef enum logic {R_IDLE, R_RESP} rstate_e;
  typedef enum logic {W_COLLECT, W_RESP} wstate_e;

  function automatic dec_t decode(input logic [15:0] a);
    dec_t d;
    d.tgt  = T_NONE;
    d.hart = '0;
    d.hi   = 1'b0;
    if (a[1:0] == 2'b00) begin
      if (a[15:5] == '0 && 32'(a[4:2]) < NHART) begin
        d.tgt  = T_MSIP;
        d.hart = a[4:2];
      end else if (a[15:6] == 10'h100 && 32'(a[5:3]) < NHART) begin
        d.tgt  = T_CMP;
        d.hart = a[5:3];
        d.hi   = a[2];
      end else if (a[15:3] == 13'h17FF) begin
        d.tgt = T_MTIME;
        d.hi  = a[2];
      end
    end
    return d;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] strb);
    logic [31:0] res;
    res = old;
    for (int unsigned b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

  // Timer state
  logic [PW-1:0]    r_presc;
  logic [63:0]      r_mtime;
  logic [63:0]      r_cmp [NHART];
  logic [NHART-1:0] r_msip;
  logic             w_wrap;

  // Read channel
  rstate_e          r_rstate, w_rstate_nxt;
  logic [IDW-1:0]   r_rid;
  logic [31:0]      r_rdata;
  logic [1:0]       r_rresp;
  dec_t             w_rdec;
  logic [31:0]      w_rd_val;
  logic [1:0]       w_rd_resp;
  logic             w_ar_hs;

  // Write channel
  wstate_e          r_wstate, w_wstate_nxt;
  logic             r_aw_held, r_w_held;
  logic [15:0]      r_awaddr;
  logic [IDW-1:0]   r_awid;
  logic [31:0]      r_wdata;
  logic [3:0]       r_wstrb;
  logic [IDW-1:0]   r_bid;
  logic [1:0]       r_bresp;
  logic [15:0]      w_waddr;
  logic [IDW-1:0]   w_wid;
  logic [31:0]      w_wdata;
  logic [3:0]       w_wstrb;
  dec_t             w_wdec;
  logic [31:0]      w_wold;
  logic [31:0]      w_wnew;
  logic             w_commit;

  assign w_wrap = (r_presc == PW'(PRESCALE - 1));

  // ---------------- read FSM ----------------
  always_ff @(posedge clock) begin
    if (reset) r_rstate <= R_IDLE;
    else       r_rstate <= w_rstate_nxt;
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    o_arready    = 1'b0;
    o_rvalid     = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        o_arready = 1'b1;
        if (i_arvalid) w_rstate_nxt = R_RESP;
      end
      R_RESP: begin
        o_rvalid = 1'b1;
        if (i_rready) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  assign w_ar_hs = o_arready & i_arvalid;
  assign o_rlast = o_rvalid;
  assign o_rid   = r_rid;
  assign o_rdata = r_rdata;
  assign o_rresp = r_rresp;

  // ---------------- write FSM ----------------
  // The commit can use the live AW/W beats, so a pair arriving together still commits in one edge.
  assign w_commit = (r_wstate == W_COLLECT) && (r_aw_held || i_awvalid) && (r_w_held || i_wvalid);

  always_ff @(posedge clock) begin
    if (reset) r_wstate <= W_COLLECT;
    else       r_wstate <= w_wstate_nxt;
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    o_awready    = 1'b0;
    o_wready     = 1'b0;
    o_bvalid     = 1'b0;
    case (r_wstate)
      W_COLLECT: begin
        o_awready = !r_aw_held;
        o_wready  = !r_w_held;
        if (w_commit) w_wstate_nxt = W_RESP;
      end
      W_RESP: begin
        o_bvalid = 1'b1;
        if (i_bready) w_wstate_nxt = W_COLLECT;
      end
      default: w_wstate_nxt = W_COLLECT;
    endcase
  end

  assign o_bid   = r_bid;
  assign o_bresp = r_bresp;

  assign w_waddr = r_aw_held ? r_awaddr : i_awaddr;
  assign w_wid   = r_aw_held ? r_awid   : i_awid;
  assign w_wdata = r_w_held  ? r_wdata  : i_wdata;
  assign w_wstrb = r_w_held  ? r_wstrb  : i_wstrb;
  assign w_rdec  = decode(i_araddr);
  assign w_wdec  = decode(w_waddr);
  assign w_wnew  = merge(w_wold, w_wdata, w_wstrb);

  // Register readback: read data for AR, and current word for the write merge
  always_comb begin
    w_rd_val  = '0;
    w_rd_resp = RESP_DECERR;
    w_wold    = '0;
    case (w_rdec.tgt)
      T_MTIME: begin
        w_rd_val  = w_rdec.hi ? r_mtime[63:32] : r_mtime[31:0];
        w_rd_resp = RESP_OKAY;
      end
      T_MSIP, T_CMP: begin
        for (int unsigned h = 0; h < NHART; h++) begin
          if (w_rdec.hart == 3'(h)) begin
            w_rd_resp = RESP_OKAY;
            if (w_rdec.tgt == T_MSIP) w_rd_val = {31'd0, r_msip[h]};
            else w_rd_val = w_rdec.hi ? r_cmp[h][63:32] : r_cmp[h][31:0];
          end
        end
      end
      default: ;
    endcase
    case (w_wdec.tgt)
      T_MTIME: w_wold = w_wdec.hi ? r_mtime[63:32] : r_mtime[31:0];
      T_CMP: begin
        for (int unsigned h = 0; h < NHART; h++) begin
          if (w_wdec.hart == 3'(h)) w_wold = w_wdec.hi ? r_cmp[h][63:32] : r_cmp[h][31:0];
        end
      end
      default: ;
    endcase
  end

  // ---------------- channel holding registers ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rid     <= '0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_awid    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bid     <= '0;
      r_bresp   <= RESP_OKAY;
    end else begin
      if (w_ar_hs) begin
        r_rid   <= i_arid;
        r_rdata <= w_rd_val;
        r_rresp <= w_rd_resp;
      end
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bid     <= w_wid;
        r_bresp   <= (w_wdec.tgt == T_NONE) ? RESP_DECERR : RESP_OKAY;
      end else begin
        if (o_awready && i_awvalid) begin
          r_aw_held <= 1'b1;
          r_awaddr  <= i_awaddr;
          r_awid    <= i_awid;
        end
        if (o_wready && i_wvalid) begin
          r_w_held <= 1'b1;
          r_wdata  <= i_wdata;
          r_wstrb  <= i_wstrb;
        end
      end
    end
  end

  // ---------------- timer and interrupt state ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_presc <= '0;
      r_mtime <= '0;
      r_msip  <= '0;
      mtip    <= '0;
      msip_o  <= '0;
      for (int unsigned h = 0; h < NHART; h++) r_cmp[h] <= '1;
    end else begin
      r_presc <= w_wrap ? '0 : r_presc + PW'(1);
      // A software write to mtime takes priority over that cycle's tick
      if (w_commit && w_wdec.tgt == T_MTIME) begin
        if (w_wdec.hi) r_mtime[63:32] <= w_wnew;
        else           r_mtime[31:0]  <= w_wnew;
      end else if (w_wrap) begin
        r_mtime <= r_mtime + 64'd1;
      end
      msip_o <= r_msip;
      for (int unsigned h = 0; h < NHART; h++) begin
        mtip[h] <= (r_mtime >= r_cmp[h]);
        if (w_commit && w_wdec.hart == 3'(h)) begin
          if (w_wdec.tgt == T_CMP) begin
            if (w_wdec.hi) r_cmp[h][63:32] <= w_wnew;
            else           r_cmp[h][31:0]  <= w_wnew;
          end
          if (w_wdec.tgt == T_MSIP && w_wstrb[0]) r_msip[h] <= w_wdata[0];
        end
      end
    end
  end

endmodule

// File: tb/tb_clint_multi_hart.sv
// Bench for clint_multi_hart: directed scenarios with literal expectations, then
// randomized AXI traffic checked every cycle against a transaction-level model.
module tb_clint_multi_hart;

  localparam int unsigned NH = 2;
  localparam int unsigned PS = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Stimulus
  logic        d_reset = 1'b1;
  logic [15:0] d_araddr = '0, d_awaddr = '0;
  logic [3:0]  d_arid = '0, d_awid = '0, d_wstrb = '0;
  logic        d_arvalid = 1'b0, d_rready = 1'b0, d_awvalid = 1'b0, d_wvalid = 1'b0, d_bready = 1'b0;
  logic [31:0] d_wdata = '0;

  // DUT outputs
  logic        o_arready, o_rlast, o_rvalid, o_awready, o_wready, o_bvalid;
  logic [31:0] o_rdata;
  logic [1:0]  o_rresp, o_bresp;
  logic [3:0]  o_rid, o_bid;
  logic [NH-1:0] mtip, msip_o;

  clint_multi_hart #(.NHART(NH), .PRESCALE(PS), .IDW(4)) dut (
    .clock(clock), .reset(d_reset),
    .i_araddr(d_araddr), .i_arid(d_arid), .i_arvalid(d_arvalid), .o_arready(o_arready),
    .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rlast(o_rlast), .o_rid(o_rid),
    .o_rvalid(o_rvalid), .i_rready(d_rready),
    .i_awaddr(d_awaddr), .i_awid(d_awid), .i_awvalid(d_awvalid), .o_awready(o_awready),
    .i_wdata(d_wdata), .i_wstrb(d_wstrb), .i_wvalid(d_wvalid), .o_wready(o_wready),
    .o_bresp(o_bresp), .o_bid(o_bid), .o_bvalid(o_bvalid), .i_bready(d_bready),
    .mtip(mtip), .msip_o(msip_o)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit            m_known = 0;
  int unsigned   m_edges = 0;
  int unsigned   m_pcnt;
  logic [63:0]   m_mtime;
  logic [63:0]   m_cmp [NH];
  logic [NH-1:0] m_msip, m_mtip, m_msipo;
  bit            m_rbusy, m_awh, m_wh, m_bbusy;
  bit            m_ar_fire, m_aw_fire, m_w_fire;
  logic [3:0]    m_rid, m_awid, m_bid, m_wstrb;
  logic [31:0]   m_rdata, m_wdata;
  logic [1:0]    m_rresp, m_bresp;
  logic [15:0]   m_awaddr;

  function automatic logic [31:0] mrg(input logic [31:0] old, input logic [31:0] dat,
                                      input logic [3:0] strb);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = dat[8*b +: 8];
    return r;
  endfunction

  task automatic model_read(input logic [15:0] a, output logic [31:0] d, output logic [1:0] r);
    int unsigned off = 32'(a);
    int unsigned h;
    d = '0;
    r = 2'b11;
    if (off % 4 == 0) begin
      if (off < 4 * NH) begin
        d = {31'd0, m_msip[off / 4]};
        r = 2'b00;
      end else if (off >= 32'h4000 && off < 32'h4000 + 8 * NH) begin
        h = (off - 32'h4000) / 8;
        d = ((off - 32'h4000) % 8 == 4) ? m_cmp[h][63:32] : m_cmp[h][31:0];
        r = 2'b00;
      end else if (off == 32'hBFF8) begin
        d = m_mtime[31:0];
        r = 2'b00;
      end else if (off == 32'hBFFC) begin
        d = m_mtime[63:32];
        r = 2'b00;
      end
    end
  endtask

  task automatic model_write(input logic [15:0] a, input logic [31:0] dat, input logic [3:0] strb,
                             output bit wrote_mtime, output logic [1:0] r);
    int unsigned off = 32'(a);
    int unsigned h;
    wrote_mtime = 0;
    r = 2'b11;
    if (off % 4 == 0) begin
      if (off < 4 * NH) begin
        if (strb[0]) m_msip[off / 4] = dat[0];
        r = 2'b00;
      end else if (off >= 32'h4000 && off < 32'h4000 + 8 * NH) begin
        h = (off - 32'h4000) / 8;
        if ((off - 32'h4000) % 8 == 4) m_cmp[h][63:32] = mrg(m_cmp[h][63:32], dat, strb);
        else                           m_cmp[h][31:0]  = mrg(m_cmp[h][31:0], dat, strb);
        r = 2'b00;
      end else if (off == 32'hBFF8 || off == 32'hBFFC) begin
        if (off == 32'hBFFC) m_mtime[63:32] = mrg(m_mtime[63:32], dat, strb);
        else                 m_mtime[31:0]  = mrg(m_mtime[31:0], dat, strb);
        wrote_mtime = 1;
        r = 2'b00;
      end
    end
  endtask

  task automatic model_step();
    logic [63:0]   pre_mtime;
    logic [63:0]   pre_cmp [NH];
    logic [NH-1:0] pre_msip;
    bit wrote = 0;
    m_ar_fire = 0;
    m_aw_fire = 0;
    m_w_fire  = 0;
    if (d_reset) begin
      m_known = 1; m_edges = 0; m_pcnt = 0; m_mtime = '0;
      for (int h = 0; h < NH; h++) m_cmp[h] = '1;
      m_msip = '0; m_mtip = '0; m_msipo = '0;
      m_rbusy = 0; m_awh = 0; m_wh = 0; m_bbusy = 0;
      m_rid = '0; m_rdata = '0; m_rresp = '0; m_bid = '0; m_bresp = '0;
      return;
    end
    pre_mtime = m_mtime;
    pre_cmp   = m_cmp;
    pre_msip  = m_msip;
    if (m_rbusy) begin
      if (d_rready) m_rbusy = 0;
    end else if (d_arvalid) begin
      m_ar_fire = 1;
      model_read(d_araddr, m_rdata, m_rresp);
      m_rid   = d_arid;
      m_rbusy = 1;
    end
    if (m_bbusy) begin
      if (d_bready) m_bbusy = 0;
    end else begin
      if (d_awvalid && !m_awh) begin
        m_aw_fire = 1; m_awh = 1; m_awaddr = d_awaddr; m_awid = d_awid;
      end
      if (d_wvalid && !m_wh) begin
        m_w_fire = 1; m_wh = 1; m_wdata = d_wdata; m_wstrb = d_wstrb;
      end
      if (m_awh && m_wh) begin
        model_write(m_awaddr, m_wdata, m_wstrb, wrote, m_bresp);
        m_bid = m_awid; m_awh = 0; m_wh = 0; m_bbusy = 1;
      end
    end
    m_pcnt = (m_pcnt + 1) % PS;
    if (m_pcnt == 0 && !wrote) m_mtime = m_mtime + 64'd1;
    for (int h = 0; h < NH; h++) m_mtip[h] = (pre_mtime >= pre_cmp[h]);
    m_msipo = pre_msip;
    m_edges++;
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clock);
    if (m_known) begin
      chk("arready", 64'(o_arready), 64'(!m_rbusy));
      chk("rvalid",  64'(o_rvalid),  64'(m_rbusy));
      chk("rlast",   64'(o_rlast),   64'(m_rbusy));
      if (m_rbusy) begin
        chk("rid",   64'(o_rid),   64'(m_rid));
        chk("rdata", 64'(o_rdata), 64'(m_rdata));
        chk("rresp", 64'(o_rresp), 64'(m_rresp));
      end
      chk("awready", 64'(o_awready), 64'(!m_bbusy && !m_awh));
      chk("wready",  64'(o_wready),  64'(!m_bbusy && !m_wh));
      chk("bvalid",  64'(o_bvalid),  64'(m_bbusy));
      if (m_bbusy) begin
        chk("bid",   64'(o_bid),   64'(m_bid));
        chk("bresp", 64'(o_bresp), 64'(m_bresp));
      end
      chk("mtip",   64'(mtip),   64'(m_mtip));
      chk("msip_o", 64'(msip_o), 64'(m_msipo));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_read(input logic [15:0] a, input logic [3:0] id,
                         output logic [31:0] d, output logic [1:0] r);
    d_arvalid = 1; d_araddr = a; d_arid = id;
    cyc();
    d_arvalid = 0;
    chk("rd_lat_rvalid", 64'(o_rvalid), 64'd1);
    chk("rd_rlast",      64'(o_rlast),  64'd1);
    chk("rd_rid",        64'(o_rid),    64'(id));
    d = o_rdata;
    r = o_rresp;
    d_rready = 1;
    cyc();
    d_rready = 0;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [31:0] dat, input logic [3:0] strb,
                          input logic [3:0] id, input int lead, input logic [1:0] exp_resp);
    d_wdata = dat; d_wstrb = strb;
    d_awaddr = a; d_awid = id;
    if (lead == 0) begin
      d_awvalid = 1; d_wvalid = 1;
      cyc();
      d_awvalid = 0; d_wvalid = 0;
    end else begin
      d_wvalid = 1;
      cyc();
      d_wvalid = 0;
      repeat (lead - 1) begin
        chk("wr_no_early_b", 64'(o_bvalid), 64'd0);
        cyc();
      end
      d_awvalid = 1;
      cyc();
      d_awvalid = 0;
    end
    chk("wr_bvalid", 64'(o_bvalid), 64'd1);
    chk("wr_bid",    64'(o_bid),    64'(id));
    chk("wr_bresp",  64'(o_bresp),  64'(exp_resp));
    d_bready = 1;
    cyc();
    d_bready = 0;
    chk("wr_bdone", 64'(o_bvalid), 64'd0);
  endtask

  function automatic logic [15:0] pick_addr();
    case ($urandom_range(0, 13))
      0:  return 16'h0000;
      1:  return 16'h0004;
      2:  return 16'h0008;
      3:  return 16'h4000;
      4:  return 16'h4004;
      5:  return 16'h4008;
      6:  return 16'h400C;
      7:  return 16'h4010;
      8:  return 16'hBFF8;
      9:  return 16'hBFFC;
      10: return 16'h0002;
      11: return 16'h8000;
      12: return 16'hBFF4;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] pick_data();
    case ($urandom_range(0, 4))
      0: return $urandom;
      1: return m_mtime[31:0] + 32'($urandom_range(0, 30));
      2: return 32'd0;
      3: return 32'd1;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  rr;

    // Reset values
    repeat (3) @(posedge clock);
    #1;
    chk("rst_arready", 64'(o_arready), 64'd1);
    chk("rst_awready", 64'(o_awready), 64'd1);
    chk("rst_wready",  64'(o_wready),  64'd1);
    chk("rst_rvalid",  64'(o_rvalid),  64'd0);
    chk("rst_bvalid",  64'(o_bvalid),  64'd0);
    chk("rst_mtip",    64'(mtip),      64'd0);
    chk("rst_msip_o",  64'(msip_o),    64'd0);
    d_reset = 0;

    // 40 idle cycles at PRESCALE=4: mtime=10 just before the AR edge
    repeat (40) cyc();
    do_read(16'hBFF8, 4'd3, rd, rr);
    chk("mtime_after_40", 64'(rd), 64'd10);
    chk("mtime_rresp",    64'(rr), 64'd0);

    // mtimecmp[1]=20 (high first): mtime hits 20 after edge 80, mtip[1] after edge 81
    do_write(16'h400C, 32'd0,  4'hF, 4'd1, 0, 2'b00);
    do_write(16'h4008, 32'd20, 4'hF, 4'd2, 0, 2'b00);
    for (int i = 0; i < 200; i++) begin
      if (mtip[1]) break;
      cyc();
    end
    chk("mtip_value",     64'(mtip),    64'b10);
    chk("mtip_rise_edge", 64'(m_edges), 64'd81);

    // msip[1] via W leading AW by 3 cycles, then cleared
    do_write(16'h0004, 32'd1, 4'b0001, 4'd5, 3, 2'b00);
    chk("msip_set", 64'(msip_o), 64'b10);
    do_write(16'h0004, 32'd0, 4'b0001, 4'd6, 0, 2'b00);
    chk("msip_clr", 64'(msip_o), 64'b00);

    // Unmapped accesses
    do_read(16'h8000, 4'd9, rd, rr);
    chk("decerr_rdata", 64'(rd), 64'd0);
    chk("decerr_rresp", 64'(rr), 64'd3);
    do_write(16'h0008, 32'd1, 4'hF, 4'd4, 0, 2'b11);
    cyc();
    chk("decerr_nochg", 64'(msip_o), 64'b00);

    // Back-pressure on both responses, then reset mid-transaction
    d_arvalid = 1; d_araddr = 16'hBFF8; d_arid = 4'd7;
    d_awvalid = 1; d_awaddr = 16'h0000; d_awid = 4'd8;
    d_wvalid = 1;  d_wdata = 32'd1;     d_wstrb = 4'b0001;
    cyc();
    d_arvalid = 0; d_awvalid = 0; d_wvalid = 0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rvalid",  64'(o_rvalid),  64'd1);
      chk("bp_arready", 64'(o_arready), 64'd0);
      chk("bp_bvalid",  64'(o_bvalid),  64'd1);
      chk("bp_awready", 64'(o_awready), 64'd0);
      cyc();
    end
    d_reset = 1;
    cyc();
    chk("rst2_rvalid",  64'(o_rvalid),  64'd0);
    chk("rst2_bvalid",  64'(o_bvalid),  64'd0);
    chk("rst2_arready", 64'(o_arready), 64'd1);
    chk("rst2_awready", 64'(o_awready), 64'd1);
    chk("rst2_msip_o",  64'(msip_o),    64'd0);
    chk("rst2_mtip",    64'(mtip),      64'd0);
    d_reset = 0;

    // mtime -> all ones (commit at edge 3), wraps to 0 on the tick at edge 4
    do_write(16'hBFFC, 32'hFFFF_FFFF, 4'hF, 4'd1, 0, 2'b00);
    do_write(16'hBFF8, 32'hFFFF_FFFF, 4'hF, 4'd2, 0, 2'b00);
    repeat (3) cyc();
    do_read(16'hBFF8, 4'd2, rd, rr);
    chk("wrap_lo", 64'(rd), 64'd0);
    do_read(16'hBFFC, 4'd3, rd, rr);
    chk("wrap_hi", 64'(rd), 64'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (!d_arvalid || m_ar_fire) begin
        d_arvalid = ($urandom_range(0, 2) == 0);
        d_araddr  = pick_addr();
        d_arid    = 4'($urandom);
      end
      if (!d_awvalid || m_aw_fire) begin
        d_awvalid = ($urandom_range(0, 2) == 0);
        d_awaddr  = pick_addr();
        d_awid    = 4'($urandom);
      end
      if (!d_wvalid || m_w_fire) begin
        d_wvalid = ($urandom_range(0, 2) == 0);
        d_wdata  = pick_data();
        d_wstrb  = 4'($urandom);
      end
      d_rready = ($urandom_range(0, 3) != 0);
      d_bready = ($urandom_range(0, 3) != 0);
      d_reset  = ($urandom_range(0, 299) == 0);
      cyc();
    end
    d_reset = 0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
